// File: rtl/fsm_divsqrt_iter.sv
// fsm_divsqrt_iter: Goldschmidt divide/sqrt control sequencer with busy/done, error abort and flush
module fsm_divsqrt_iter #(
  parameter int unsigned ITER    = 3,
  parameter bit          SQRT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       op_type,
  input  logic       error,
  input  logic       flush,
  output logic       busy,
  output logic       done,
  output logic       err_flag,
  output logic       load_rega,
  output logic       load_regb,
  output logic       load_regc,
  output logic       load_regd,
  output logic       load_regs,
  output logic       load_regr,
  output logic [2:0] sel_muxa,
  output logic [2:0] sel_muxb,
  output logic       sel_muxr,
  output logic [3:0] iter
);
  typedef enum logic [3:0] {
    IDLE, D_PRE, D_ITB, D_ITA, S_PRE0, S_PRE1, S_ITB, S_ITD, S_ITA, QUOT, REM, DONE
  } state_t;
  state_t     state_q, state_d;
  logic [3:0] iter_q, iter_d;
  logic       op_q, op_d;
  logic       err_q, err_d;
  logic       last;
  assign last = iter_q == 4'(ITER - 1);
  // state, iteration index, latched op and abort flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      iter_q  <= 4'd0;
      op_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end
  // next-state and per-state datapath control decode; flush/error override loads and transition
  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    op_d      = op_q;
    err_d     = err_q;
    busy      = state_q != IDLE;
    done      = 1'b0;
    err_flag  = 1'b0;
    load_rega = 1'b0;
    load_regb = 1'b0;
    load_regc = 1'b0;
    load_regd = 1'b0;
    load_regs = 1'b0;
    load_regr = 1'b0;
    sel_muxa  = 3'd0;
    sel_muxb  = 3'd0;
    sel_muxr  = 1'b0;
    iter      = iter_q;
    case (state_q)
      IDLE: if (start) begin
        op_d   = op_type;
        iter_d = 4'd0;
        err_d  = op_type & ~SQRT_EN;
        if (!op_type) begin
          load_regb = 1'b1;
          sel_muxa  = 3'd1;
          sel_muxb  = 3'd1;
          state_d   = D_PRE;
        end else if (SQRT_EN) begin
          load_regb = 1'b1;
          sel_muxa  = 3'd2;
          state_d   = S_PRE0;
        end else begin
          state_d = DONE;
        end
      end
      D_PRE: begin
        load_rega = 1'b1;
        load_regc = 1'b1;
        sel_muxa  = 3'd2;
        state_d   = D_ITB;
      end
      D_ITB: begin
        load_regb = 1'b1;
        sel_muxa  = 3'd3;
        sel_muxb  = 3'd3;
        state_d   = last ? QUOT : D_ITA;
      end
      D_ITA: begin
        load_rega = 1'b1;
        load_regc = 1'b1;
        sel_muxb  = 3'd2;
        iter_d    = iter_q + 4'd1;
        state_d   = D_ITB;
      end
      S_PRE0: begin
        load_regd = 1'b1;
        sel_muxa  = 3'd2;
        sel_muxb  = 3'd1;
        state_d   = S_PRE1;
      end
      S_PRE1: begin
        load_rega = 1'b1;
        load_regc = 1'b1;
        sel_muxa  = 3'd1;
        sel_muxb  = 3'd4;
        state_d   = S_ITB;
      end
      S_ITB: begin
        load_regb = 1'b1;
        sel_muxa  = 3'd3;
        sel_muxb  = 3'd3;
        state_d   = S_ITD;
      end
      S_ITD: begin
        load_regd = 1'b1;
        sel_muxb  = 3'd3;
        state_d   = S_ITA;
      end
      S_ITA: begin
        load_rega = 1'b1;
        load_regc = 1'b1;
        sel_muxa  = 3'd4;
        sel_muxb  = 3'd2;
        iter_d    = last ? iter_q : iter_q + 4'd1;
        state_d   = last ? QUOT : S_ITB;
      end
      QUOT: begin
        load_regs = 1'b1;
        state_d   = REM;
      end
      REM: begin
        load_regr = 1'b1;
        sel_muxr  = 1'b1;
        sel_muxa  = op_q ? 3'd3 : 3'd0;
        sel_muxb  = op_q ? 3'd6 : 3'd0;
        state_d   = DONE;
      end
      DONE: begin
        done     = 1'b1;
        err_flag = err_q;
        iter_d   = 4'd0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && state_q != DONE && (flush || error)) begin
      load_rega = 1'b0;
      load_regb = 1'b0;
      load_regc = 1'b0;
      load_regd = 1'b0;
      load_regs = 1'b0;
      load_regr = 1'b0;
      iter_d    = flush ? 4'd0 : iter_q;
      err_d     = flush ? err_q : 1'b1;
      state_d   = flush ? IDLE : DONE;
    end
  end
endmodule

// File: tb/tb_fsm_divsqrt_iter.sv
// tb_fsm_divsqrt_iter: randomized scoreboard check of four parameterisations against a per-cycle schedule model
module tb_fsm_divsqrt_iter;
  localparam int NI = 4;
  localparam int ITERS[NI] = '{3, 1, 15, 3};
  localparam bit SQEN[NI]  = '{1'b1, 1'b1, 1'b1, 1'b0};
  typedef struct packed {
    logic       busy;
    logic       done;
    logic       errf;
    logic [5:0] ld;
    logic [2:0] ma;
    logic [2:0] mb;
    logic       mr;
    logic [3:0] it;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_r[NI];
  logic op_r[NI];
  logic error_r[NI];
  logic flush_r[NI];
  vec_t dut_v[NI];
  vec_t exp_q[NI][$];
  bit   mon_on = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  always #5 clk = ~clk;
  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : u
      logic la, lb, lc, ld, ls, lr, mr, busy, done, ef;
      logic [2:0] ma, mb;
      logic [3:0] it;
      fsm_divsqrt_iter #(.ITER(ITERS[g]), .SQRT_EN(SQEN[g])) dut (
        .clk(clk), .reset(reset), .start(start_r[g]), .op_type(op_r[g]),
        .error(error_r[g]), .flush(flush_r[g]), .busy(busy), .done(done),
        .err_flag(ef), .load_rega(la), .load_regb(lb), .load_regc(lc),
        .load_regd(ld), .load_regs(ls), .load_regr(lr), .sel_muxa(ma),
        .sel_muxb(mb), .sel_muxr(mr), .iter(it)
      );
      assign dut_v[g] = {busy, done, ef, la, lb, lc, ld, ls, lr, ma, mb, mr, it};
    end
  endgenerate
  function automatic vec_t v(bit b, bit [5:0] l, bit [2:0] a, bit [2:0] bm, bit r, int k);
    return '{busy: b, done: 1'b0, errf: 1'b0, ld: l, ma: a, mb: bm, mr: r, it: 4'(k)};
  endfunction
  function automatic vec_t dn(bit e, logic [3:0] k);
    return '{busy: 1'b1, done: 1'b1, errf: e, ld: 6'd0, ma: 3'd0, mb: 3'd0, mr: 1'b0, it: k};
  endfunction
  task automatic build(int i, bit op);
    int n = ITERS[i];
    if (op && !SQEN[i]) begin
      exp_q[i].push_back(v(0, 6'b000000, 0, 0, 0, 0));
      exp_q[i].push_back(dn(1'b1, 4'd0));
      return;
    end
    if (!op) begin
      exp_q[i].push_back(v(0, 6'b010000, 1, 1, 0, 0));
      exp_q[i].push_back(v(1, 6'b101000, 2, 0, 0, 0));
      for (int k = 0; k < n; k++) begin
        exp_q[i].push_back(v(1, 6'b010000, 3, 3, 0, k));
        if (k < n - 1) exp_q[i].push_back(v(1, 6'b101000, 0, 2, 0, k));
      end
    end else begin
      exp_q[i].push_back(v(0, 6'b010000, 2, 0, 0, 0));
      exp_q[i].push_back(v(1, 6'b000100, 2, 1, 0, 0));
      exp_q[i].push_back(v(1, 6'b101000, 1, 4, 0, 0));
      for (int k = 0; k < n; k++) begin
        exp_q[i].push_back(v(1, 6'b010000, 3, 3, 0, k));
        exp_q[i].push_back(v(1, 6'b000100, 0, 3, 0, k));
        exp_q[i].push_back(v(1, 6'b101000, 4, 2, 0, k));
      end
    end
    exp_q[i].push_back(v(1, 6'b000010, 0, 0, 0, n - 1));
    exp_q[i].push_back(op ? v(1, 6'b000001, 3, 6, 1, n - 1) : v(1, 6'b000001, 0, 0, 1, n - 1));
    exp_q[i].push_back(dn(1'b0, 4'(n - 1)));
  endtask
  task automatic trim(int i);
    while (exp_q[i].size() > 1) void'(exp_q[i].pop_back());
  endtask
  task automatic model(int i);
    vec_t f;
    if (exp_q[i].size() == 0) begin
      if (start_r[i]) begin
        build(i, op_r[i]);
        if (reset) trim(i);
      end
    end else if (reset) begin
      trim(i);
    end else if (exp_q[i][0].busy && !exp_q[i][0].done && (flush_r[i] || error_r[i])) begin
      f = exp_q[i][0];
      f.ld = 6'd0;
      trim(i);
      exp_q[i][0] = f;
      if (!flush_r[i]) exp_q[i].push_back(dn(1'b1, f.it));
    end
  endtask
  task automatic step(int pstart, int perr, int pflush, int prst);
    @(posedge clk);
    #1;
    reset = $urandom_range(0, 999) < prst;
    for (int i = 0; i < NI; i++) begin
      start_r[i] = $urandom_range(0, 99) < pstart;
      op_r[i]    = 1'($urandom_range(0, 1));
      error_r[i] = $urandom_range(0, 999) < perr;
      flush_r[i] = $urandom_range(0, 999) < pflush;
    end
    for (int i = 0; i < NI; i++) model(i);
  endtask
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        for (int i = 0; i < NI; i++) begin
          e = exp_q[i].size() != 0 ? exp_q[i].pop_front() : '0;
          n_cmp++;
          if (dut_v[i] !== e) begin
            n_bad++;
            $display("FAIL u%0d outputs at %0t: got %h required %h", i, $time, dut_v[i], e);
          end
        end
      end
    end
  end
  initial begin
    int w;
    for (int i = 0; i < NI; i++) begin
      start_r[i] = 1'b0;
      op_r[i]    = 1'b0;
      error_r[i] = 1'b0;
      flush_r[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if (dut_v[i] !== '0) begin
        n_bad++;
        $display("FAIL u%0d reset state at %0t: got %h required 0", i, $time, dut_v[i]);
      end
    end
    mon_on = 1'b1;
    repeat (400) step(60, 0, 0, 0);
    repeat (2500) step(50, 15, 10, 3);
    repeat (80) step(0, 0, 0, 0);
    mon_on = 1'b0;
    @(posedge clk);
    #1;
    start_r[0] = 1'b1;
    op_r[0]    = 1'b0;
    @(posedge clk);
    #1;
    start_r[0] = 1'b0;
    w = 0;
    while (!dut_v[0].done && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    n_cmp++;
    if (dut_v[0].done !== 1'b1) begin
      n_bad++;
      $display("FAIL u0 wait for done expired at %0t", $time);
    end
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fsm_divsqrt_iter.md
# fsm_divsqrt_iter

Parametrised control FSM for the FPU's multiplicative (Goldschmidt) divide/square-root datapath. It sequences the operand registers (A, B, C, D), the quotient-set register (q/qm/qp) and the remainder register through a configurable number of refinement iterations. It adds a busy/done handshake, an error abort, a flush, and a build-time square-root disable. It sits between the FPU issue logic and the shared divide/sqrt multiplier datapath.

## Interface
- ITER, 3, number of refinement iterations; legal range 1..15.
- SQRT_EN, 1, 1 enables the square-root path; 0 treats any sqrt request as an error.
- clk  in  1  clock; reset reset, synchronous, active-high
- reset  in  1  synchronous active-high reset
- start  in  1  operation request; sampled only in IDLE
- op_type  in  1  0 divide, 1 square root; sampled with start
- error  in  1  datapath exception; aborts the active operation
- flush  in  1  pipeline flush; abandons the active operation silently
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err_flag  out  1  high with done when the completion was an abort
- load_rega, load_regb, load_regc, load_regd  out  1 each  operand register enables
- load_regs  out  1  q/qm/qp register enable
- load_regr  out  1  remainder register enable
- sel_muxa, sel_muxb  out  3 each  datapath operand mux selects
- sel_muxr  out  1  remainder mux select
- iter  out  4  current iteration index, 0-based

## Operation
- States: IDLE, D_PRE, D_ITB, D_ITA, S_PRE0, S_PRE1, S_ITB, S_ITD, S_ITA, QUOT, REM, DONE.
- Output encoding: unlisted outputs are 0 in every state.
- IDLE, start=0: all outputs 0; stay in IDLE.
- IDLE, start=1, op_type=0: load_regb=1, sel_muxa=001, sel_muxb=001; go to D_PRE.
- IDLE, start=1, op_type=1, SQRT_EN=1: load_regb=1, sel_muxa=010, sel_muxb=000; go to S_PRE0.
- IDLE, start=1, op_type=1, SQRT_EN=0: no loads; go to DONE with err_flag latched.
- The op is latched on accept.
- Divide path:
  - D_PRE: load_rega=1, load_regc=1, sel_muxa=010, sel_muxb=000.
  - D_ITB: load_regb=1, sel_muxa=011, sel_muxb=011. Goes to QUOT when iter==ITER-1, else to D_ITA.
  - D_ITA: load_rega=1, load_regc=1, sel_muxa=000, sel_muxb=010; increments iter; goes to D_ITB.
- Sqrt path:
  - S_PRE0: load_regd=1, sel_muxa=010, sel_muxb=001.
  - S_PRE1: load_rega=1, load_regc=1, sel_muxa=001, sel_muxb=100.
  - S_ITB: load_regb=1, sel_muxa=011, sel_muxb=011.
  - S_ITD: load_regd=1, sel_muxa=000, sel_muxb=011.
  - S_ITA: load_rega=1, load_regc=1, sel_muxa=100, sel_muxb=010. Goes to QUOT when iter==ITER-1, else increments iter and goes to S_ITB.
- QUOT: load_regs=1; all selects 000.
- REM: load_regr=1, sel_muxr=1.
  - Divide: sel_muxa=000, sel_muxb=000.
  - Sqrt: sel_muxa=011, sel_muxb=110.
- DONE: done=1, err_flag as latched; go to IDLE.
- iter clears on accept in IDLE. It holds during the pre, QUOT, REM and DONE states.
- Priority in any busy state except DONE: reset > flush > error > normal transition.
  - flush=1: next state IDLE, no done, no err_flag; loads in the flush cycle are forced to 0.
  - error=1: next state DONE with err_flag latched; loads in the error cycle are forced to 0.
- DONE ignores start, error and flush, and always returns to IDLE. A start is accepted one cycle after done at the earliest.

## Timing
- Reset: state IDLE, iter=0, err_flag latch cleared. Every output is 0 in the cycle following reset.
- Accept cycle T is the IDLE cycle with start=1.
- Divide: done at T+2·ITER+3; ITER=3 gives T+9.
- Sqrt: done at T+3·ITER+5; ITER=3 gives T+14.
- Error observed at cycle E: done=1, err_flag=1 at E+1.
- Flush observed at cycle F: IDLE at F+1; a new start can be accepted at F+1.
- Reset mid-operation: IDLE on the next edge, no done.
- All outputs are decoded combinationally from the registered state, plus start/op_type in IDLE.

## Test plan
- ITER=3 divide, start at T: load_regb pulses at T, T+2, T+4, T+6; load_regs at T+7; load_regr with sel_muxr=1 at T+8; done=1, err_flag=0 at T+9; busy high T+1..T+9.
- ITER=3 sqrt: load_regd pulses at T+1, T+4, T+7, T+10; sel_muxb=110 at T+13; done at T+14.
- ITER=1 and ITER=15 divide: done at T+5 and T+33; iter reaches 0 and 14 respectively.
- Error at the second D_ITB (T+4): no loads at T+4; done=1, err_flag=1 at T+5; IDLE at T+6.
- Flush at S_ITD (T+4) with start held high: no done; the operation is re-accepted at T+5 and done at T+19.
- SQRT_EN=0, sqrt request at T: done=1, err_flag=1 at T+1, no loads. Also: reset asserted at T+3 of a divide gives IDLE at T+4 and no done.
